// File: rtl/ct_spsram_arb_pkg.sv
// Shared types, constants and helpers for the 256x100 single-port SRAM
// controller/arbiter: FSM state, round-robin history encoding and the
// lane-mask to active-low bit-write-enable expansion.
package ct_spsram_arb_pkg;

  localparam int LANE_WIDTH = 25;
  localparam int LANES      = 4;
  localparam int WEN_WIDTH  = LANES * LANE_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Which requester received the most recent grant.
  typedef enum logic {
    RR_WRITE = 1'b0,
    RR_READ  = 1'b1
  } rr_t;

  // A set mask bit enables its whole lane, so the lane's WEN bits go low.
  function automatic logic [WEN_WIDTH-1:0] lane_mask_to_wen(input logic [LANES-1:0] mask);
    logic [WEN_WIDTH-1:0] wen;
    wen = '1;
    for (int k = 0; k < LANES; k++) begin
      if (mask[k]) begin
        wen[k*LANE_WIDTH +: LANE_WIDTH] = '0;
      end
    end
    return wen;
  endfunction

endpackage

// File: rtl/ct_spsram_256x100_arb_cmd_reg.sv
// Registered SRAM command port. Every control seen by the macro comes
// straight from a flop; address and data only reload when a command
// actually uses them so they hold across idle cycles.
module ct_spsram_cmd_reg
  import ct_spsram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 100
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cen,
  input  logic                  i_gwen,
  input  logic [DATA_WIDTH-1:0] i_wen,
  input  logic                  i_a_ld,
  input  logic [ADDR_WIDTH-1:0] i_a,
  input  logic                  i_d_ld,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic                  o_cen,
  output logic                  o_gwen,
  output logic [DATA_WIDTH-1:0] o_wen,
  output logic [ADDR_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_d
);

  logic                  r_cen;
  logic                  r_gwen;
  logic [DATA_WIDTH-1:0] r_wen;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_d;

  // Control flops: reset to an idle (deselected, no-write) command.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cen  <= 1'b1;
      r_gwen <= 1'b1;
      r_wen  <= '1;
    end else begin
      r_cen  <= i_cen;
      r_gwen <= i_gwen;
      r_wen  <= i_wen;
    end
  end

  // Address/data flops: load only when the issued command needs them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a <= '0;
      r_d <= '0;
    end else begin
      if (i_a_ld) r_a <= i_a;
      if (i_d_ld) r_d <= i_d;
    end
  end

  assign o_cen  = r_cen;
  assign o_gwen = r_gwen;
  assign o_wen  = r_wen;
  assign o_a    = r_a;
  assign o_d    = r_d;

endmodule

// File: rtl/ct_spsram_256x100_arb.sv
// Controller/arbiter in front of a 256x100 single-port SRAM macro.
// Clears the array after reset (or on init_req), then shares the port
// between one writer and one reader with round-robin tie-breaking.
module ct_spsram_256x100_arb
  import ct_spsram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 100
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic                  init_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [LANES-1:0]      wr_mask,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  rr_t                   r_rr_last;
  rr_t                   w_rr_nxt;
  logic                  w_pick_wr;
  logic                  w_pick_rd;

  logic                  w_cmd_cen;
  logic                  w_cmd_gwen;
  logic [DATA_WIDTH-1:0] w_cmd_wen;
  logic                  w_cmd_a_ld;
  logic [ADDR_WIDTH-1:0] w_cmd_a;
  logic                  w_cmd_d_ld;
  logic [DATA_WIDTH-1:0] w_cmd_d;

  logic                  r_rd_vld_p1;
  logic                  r_rd_vld_p2;

  assign init_busy = (r_state == ST_INIT);
  assign init_done = (r_state == ST_INIT) && (r_cnt == LAST_ADDR);

  // Next-state, arbitration and command selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr_last;
    w_pick_wr   = 1'b0;
    w_pick_rd   = 1'b0;
    wr_gnt      = 1'b0;
    rd_gnt      = 1'b0;
    w_cmd_cen   = 1'b1;
    w_cmd_gwen  = 1'b1;
    w_cmd_wen   = '1;
    w_cmd_a_ld  = 1'b0;
    w_cmd_a     = '0;
    w_cmd_d_ld  = 1'b0;
    w_cmd_d     = '0;

    case (r_state)
      ST_INIT: begin
        // Sweep: one full-width zero write per cycle.
        w_cmd_cen  = 1'b0;
        w_cmd_gwen = 1'b0;
        w_cmd_wen  = '0;
        w_cmd_a_ld = 1'b1;
        w_cmd_a    = r_cnt;
        w_cmd_d_ld = 1'b1;
        w_cmd_d    = '0;
        if (r_cnt == LAST_ADDR) begin
          // Counter saturates here so the sweep never repeats by itself.
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (init_req) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end else begin
          // On a tie, serve whoever did not get the last grant.
          w_pick_wr = wr_req && (!rd_req || (r_rr_last == RR_READ));
          w_pick_rd = rd_req && !w_pick_wr;
          wr_gnt    = w_pick_wr;
          rd_gnt    = w_pick_rd;
          if (w_pick_wr) begin
            w_rr_nxt   = RR_WRITE;
            w_cmd_cen  = 1'b0;
            w_cmd_gwen = 1'b0;
            w_cmd_wen  = lane_mask_to_wen(wr_mask);
            w_cmd_a_ld = 1'b1;
            w_cmd_a    = wr_addr;
            w_cmd_d_ld = 1'b1;
            w_cmd_d    = wr_data;
          end else if (w_pick_rd) begin
            w_rr_nxt   = RR_READ;
            w_cmd_cen  = 1'b0;
            w_cmd_a_ld = 1'b1;
            w_cmd_a    = rd_addr;
          end
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state, sweep counter and round-robin history.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      r_rr_last <= RR_READ;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rr_last <= w_rr_nxt;
    end
  end

  // Read-valid pipeline: command edge, then macro access edge.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rd_vld_p1 <= 1'b0;
      r_rd_vld_p2 <= 1'b0;
    end else begin
      r_rd_vld_p1 <= rd_gnt;
      r_rd_vld_p2 <= r_rd_vld_p1;
    end
  end

  assign rd_vld  = r_rd_vld_p2;
  assign rd_data = sram_q;

  ct_spsram_cmd_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmd_reg (
    .i_clk   (forever_cpuclk),
    .i_rst_n (cpurst_b),
    .i_cen   (w_cmd_cen),
    .i_gwen  (w_cmd_gwen),
    .i_wen   (w_cmd_wen),
    .i_a_ld  (w_cmd_a_ld),
    .i_a     (w_cmd_a),
    .i_d_ld  (w_cmd_d_ld),
    .i_d     (w_cmd_d),
    .o_cen   (sram_cen),
    .o_gwen  (sram_gwen),
    .o_wen   (sram_wen),
    .o_a     (sram_a),
    .o_d     (sram_d)
  );

endmodule

// File: tb/tb_ct_spsram_256x100_arb.sv
// Directed bench for ct_spsram_256x100_arb with a behavioural SRAM macro.
module tb_ct_spsram_256x100_arb;

  localparam int AW = 8;
  localparam int DW = 100;
  localparam logic [DW-1:0] D1     = 100'h123456789ABCDEF0123456789;
  localparam logic [DW-1:0] D2     = 100'h0000000000000000000000ABC;
  localparam logic [DW-1:0] ONES   = {DW{1'b1}};
  localparam logic [DW-1:0] MASKED = {{25{1'b1}}, {25{1'b0}}, {25{1'b1}}, {25{1'b0}}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_req;
  logic          init_busy;
  logic          init_done;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_mask;
  logic          wr_gnt;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] q_r;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ct_spsram_256x100_arb dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .init_req       (init_req),
    .init_busy      (init_busy),
    .init_done      (init_done),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_mask        (wr_mask),
    .wr_gnt         (wr_gnt),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_gnt         (rd_gnt),
    .rd_vld         (rd_vld),
    .rd_data        (rd_data),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Behavioural macro: bit-masked write, registered read.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            q_r <= mem[sram_a];
    end
  end
  assign sram_q = q_r;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
    logic got;
    got     = 1'b0;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_mask = m;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (wr_gnt) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    check_val("wr_gnt", got, 1);
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic got;
    got     = 1'b0;
    rd_req  = 1'b1;
    rd_addr = a;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (rd_gnt) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    check_val({tag, "_gnt"}, got, 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    check_val({tag, "_vld_n1"}, rd_vld, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val({tag, "_vld_n2"}, rd_vld, 1);
    check_val({tag, "_data"}, rd_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       any_gnt;
    logic       vld_seen;
    int         sweep;
    int         nvld;

    rst_n    = 1'b0;
    init_req = 1'b0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_mask  = '0;
    rd_req   = 1'b0;
    rd_addr  = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_cen", sram_cen, 1);
    check_val("rst_gwen", sram_gwen, 1);
    check_val("rst_wen", sram_wen, ONES);
    check_val("rst_a", sram_a, 0);
    check_val("rst_d", sram_d, 0);
    check_val("rst_rd_vld", rd_vld, 0);
    check_val("rst_wr_gnt", wr_gnt, 0);
    check_val("rst_rd_gnt", rd_gnt, 0);
    check_val("rst_init_done", init_done, 0);
    check_val("rst_init_busy", init_busy, 1);

    // Sweep after release: 256 zero writes, done in the last one.
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      check_val("sweep_busy", init_busy, 1);
      check_val("sweep_done", init_done, (i == 255));
      @(posedge clk); #1;
      check_val("sweep_a", sram_a, i);
      check_val("sweep_cen", sram_cen, 0);
      check_val("sweep_gwen", sram_gwen, 0);
      check_val("sweep_wen", sram_wen, 0);
      check_val("sweep_d", sram_d, 0);
      @(negedge clk);
    end
    check_val("run_busy", init_busy, 0);
    check_val("run_done", init_done, 0);
    @(posedge clk); #1;
    check_val("idle_cen", sram_cen, 1);
    check_val("idle_gwen", sram_gwen, 1);
    check_val("idle_a_hold", sram_a, 255);

    // Full write then read back.
    do_write(8'h5A, D1, 4'b1111);
    do_read("rd5a", 8'h5A, D1);

    // Partial-lane write over all ones.
    do_write(8'h33, ONES, 4'b1111);
    do_write(8'h33, '0, 4'b0101);
    do_read("rdmask", 8'h33, MASKED);

    // Both requesters held: alternate W,R,...; read data 2 cycles later.
    wr_req  = 1'b1;
    wr_addr = 8'h10;
    wr_data = D2;
    wr_mask = 4'b1111;
    rd_req  = 1'b1;
    rd_addr = 8'h5A;
    nvld    = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 6) begin
        check_val("rr_wr_gnt", wr_gnt, (i % 2 == 0));
        check_val("rr_rd_gnt", rd_gnt, (i % 2 == 1));
      end
      check_val("rr_rd_vld", rd_vld, (i == 3 || i == 5 || i == 7));
      if (rd_vld) begin
        nvld++;
        check_val("rr_rd_data", rd_data, D1);
      end
      @(posedge clk); #1;
      if (i == 5) begin
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
    end
    check_val("rr_vld_count", nvld, 3);
    do_read("rd10", 8'h10, D2);

    // init_req beats a pending read; sweep; read granted first RUN cycle.
    init_req = 1'b1;
    rd_req   = 1'b1;
    rd_addr  = 8'h5A;
    @(negedge clk);
    check_val("ireq_rd_gnt", rd_gnt, 0);
    check_val("ireq_wr_gnt", wr_gnt, 0);
    @(posedge clk); #1;
    init_req = 1'b0;
    sweep    = 0;
    any_gnt  = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!init_busy) break;
      sweep++;
      any_gnt = any_gnt | rd_gnt | wr_gnt;
      @(posedge clk); #1;
    end
    check_val("ireq_sweep_len", sweep, 256);
    check_val("ireq_no_gnt", any_gnt, 0);
    check_val("ireq_first_run_gnt", rd_gnt, 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    check_val("ireq_vld_n1", rd_vld, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("ireq_vld_n2", rd_vld, 1);
    check_val("ireq_data_zero", rd_data, 0);
    @(posedge clk); #1;

    // Reset right after a read grant.
    do_write(8'h77, D1, 4'b1111);
    rd_req  = 1'b1;
    rd_addr = 8'h5A;
    @(negedge clk);
    check_val("mrst_rd_gnt", rd_gnt, 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    check_val("mrst_cmd_cen", sram_cen, 0);
    check_val("mrst_cmd_a", sram_a, 8'h5A);
    check_val("mrst_cmd_d", sram_d, D1);
    rst_n = 1'b0;
    #1;
    check_val("mrst_cen", sram_cen, 1);
    check_val("mrst_gwen", sram_gwen, 1);
    check_val("mrst_wen", sram_wen, ONES);
    check_val("mrst_a", sram_a, 0);
    check_val("mrst_d", sram_d, 0);
    check_val("mrst_busy", init_busy, 1);
    vld_seen = rd_vld;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vld_seen = vld_seen | rd_vld;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vld_seen = vld_seen | rd_vld;
      check_val("mrst_sweep_a", sram_a, i);
      check_val("mrst_sweep_cen", sram_cen, 0);
      @(negedge clk);
      vld_seen = vld_seen | rd_vld;
    end
    check_val("mrst_no_vld", vld_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ct_spsram_256x100_arb.md
Name: ct_spsram_256x100_arb

Overview:
- Controller and arbiter in front of one 256x100 single-port SRAM macro with active-low CEN/GWEN/per-bit WEN and a registered read.
- After reset, or on request, it clears all 256 entries to zero.
- It then shares the single port between one write requester and one read requester, using round-robin arbitration.
- It sits between the IFU/LSU-side table logic and the SRAM wrapper. All SRAM-side outputs are registered, so the macro sees clean flop-driven controls.

Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 100, data bits.
- LANE_WIDTH, 25, bits per write lane; LANES = DATA_WIDTH/LANE_WIDTH = 4.

Ports:
- forever_cpuclk  in  1  clock; all state on rising edge.
- cpurst_b  in  1  asynchronous active-low reset.
- init_req  in  1  pulse: start clear sweep (honoured only in RUN).
- init_busy  out  1  high while the sweep issues commands.
- init_done  out  1  one-cycle pulse when the last sweep command is issued.
- wr_req  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_mask  in  LANES  active-high lane enables; lane k covers bits [25k+24:25k].
- wr_gnt  out  1  write accepted this cycle.
- rd_req  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_gnt  out  1  read accepted this cycle.
- rd_vld  out  1  read data valid.
- rd_data  out  DATA_WIDTH  read data; equals sram_q while rd_vld is high.
- sram_a  out  ADDR_WIDTH  macro address (registered).
- sram_cen  out  1  macro chip enable, active low (registered).
- sram_gwen  out  1  macro global write enable, active low (registered).
- sram_wen  out  DATA_WIDTH  macro bit write enables, active low (registered).
- sram_d  out  DATA_WIDTH  macro write data (registered).
- sram_q  in  DATA_WIDTH  macro read data, valid one cycle after the command edge.

Behaviour:
- Reset values while cpurst_b is low:
  - SRAM side: sram_cen=1, sram_gwen=1, sram_wen=all 1s, sram_a=0, sram_d=0.
  - Status and grants: rd_vld=0, wr_gnt=0, rd_gnt=0, init_done=0, init_busy=1.
  - Internal: state=INIT, init counter cnt=0, rr_last=READ (so the first tie goes to write).
- FSM state INIT:
  - Each cycle issues a write of zero to address cnt: gwen=0, wen=all 0s, d=0, cen=0. cnt increments.
  - wr_gnt and rd_gnt are held at 0; incoming requests wait.
  - The cycle with cnt==DEPTH-1 pulses init_done. The next state is RUN, with init_busy=0.
  - The sweep is exactly 256 command cycles after reset release.
- FSM state RUN:
  - Only rd_req high: grant read. Only wr_req high: grant write.
  - Both high: grant the opposite of rr_last. Update rr_last on every grant.
  - No request: issue an idle command (cen=1, gwen=1, wen all 1s). sram_a and sram_d hold their previous values.
  - init_req high (it has priority over requests that cycle): no grant. Go to INIT with cnt=0 and init_busy=1 from the next cycle.
- Grants are combinational from the request and state in cycle N. A requester must hold req and its payload stable until it sees gnt.
- Command register loads at the end of cycle N:
  - Write: a=wr_addr, gwen=0, d=wr_data, wen lane k = all 0s if wr_mask[k] else all 1s.
  - wr_mask=0 with wr_req still consumes a grant and issues gwen=0 with wen all 1s, which is a no-op write.
  - Read: a=rd_addr, gwen=1, wen all 1s.
- Read latency:
  - Cycle N+1: the macro captures the command.
  - Cycle N+2: rd_vld=1 and rd_data=sram_q.
  - rd_vld is a 2-stage pipeline of rd_gnt. Back-to-back read grants give back-to-back rd_vld.
- Write followed by read of the same address: a read granted at N+1 after a write granted at N returns the new data. The macro is write-then-read ordered; no bypass is needed.
- Reset mid-operation: in-flight rd_vld is squashed and the sweep restarts from address 0 after release.
- cnt is ADDR_WIDTH+1 bits wide or saturates at DEPTH-1; it must not wrap into a second sweep.

Decomposition:
- Shared package ct_spsram_arb_pkg holds:
  - state enum {INIT, RUN};
  - the rr_last encoding;
  - LANES and LANE_WIDTH constants;
  - a function for lane-mask-to-WEN expansion.
- One sub-module, ct_spsram_cmd_reg, holds the registered SRAM command flops with their reset values. The FSM, arbiter and read-valid pipeline stay in the top module.

Test Plan:
- Reset release, no requests. Required:
  - init_busy stays high for exactly 256 cycles;
  - sram_a steps 0..255 with gwen=0, wen=0, d=0;
  - init_done pulses when sram_a is loaded with 255;
  - sram_cen=1 afterwards.
- RUN: write addr 0x5A, data 0x123456789ABCDEF0123456789 (truncated to 100 bits), mask 4'b1111; then read 0x5A. Required:
  - rd_vld two cycles after rd_gnt;
  - rd_data equals the written data on an SRAM model.
- Write mask 4'b0101 to an address holding all 1s, data all 0s; then read. Required: lanes 0 and 2 are zero, lanes 1 and 3 are all 1s.
- wr_req and rd_req held high for 6 cycles. Required:
  - grants alternate W,R,W,R,W,R;
  - 3 rd_vld pulses, each 2 cycles after its grant.
- init_req pulsed in RUN while rd_req is high. Required:
  - no grant that cycle;
  - 256-cycle sweep follows;
  - read granted on the first RUN cycle and returns 0.
- cpurst_b asserted one cycle after a read grant. Required:
  - rd_vld never rises;
  - SRAM-side outputs immediately show their reset values;
  - sweep restarts at address 0.
